// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: round-robin grant of NREQ requesters onto the single
// register-file write port, with a registered output stage and a busy scoreboard.
module reg_wb_arbiter #(
  parameter int unsigned NREQ   = 3,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic [NREQ-1:0]          ReqValid,
  input  logic [NREQ*ADDR_W-1:0]   ReqAddr,
  input  logic [NREQ*DATA_W-1:0]   ReqData,
  output logic [NREQ-1:0]          ReqReady,
  input  logic                     RsvValid,
  input  logic [ADDR_W-1:0]        RsvAddr,
  output logic [ADDR_W-1:0]        WriteReg,
  output logic [DATA_W-1:0]        WriteData,
  output logic                     RegWriteEn,
  output logic [(2**ADDR_W)-1:0]   BusyMask
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0]  ptr;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W:0]    cand;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_any;
  logic              transfer;
  logic [NREQ-1:0]   grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  // Rotating priority search: offset k from ptr, wrapped by a single subtract
  // since ptr + k never reaches 2*NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NREQ)) begin
        cand = cand - (PTR_W+1)'(NREQ);
      end
      if (!grant_any && ReqValid[cand[PTR_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    grant    = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == PTR_W'(i)) begin
        sel_addr = ReqAddr[i*ADDR_W +: ADDR_W];
        sel_data = ReqData[i*DATA_W +: DATA_W];
        grant[i] = grant_any;
      end
    end
  end

  assign transfer = grant_any & Rst_n;
  assign ReqReady = Rst_n ? grant : '0;
  assign ptr_next = (grant_idx == PTR_W'(NREQ-1)) ? '0 : grant_idx + PTR_W'(1);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr        <= '0;
      WriteReg   <= '0;
      WriteData  <= '0;
      RegWriteEn <= 1'b0;
    end else if (transfer) begin
      ptr        <= ptr_next;
      WriteReg   <= sel_addr;
      WriteData  <= sel_data;
      RegWriteEn <= (sel_addr != '0);
    end else begin
      RegWriteEn <= 1'b0;
    end
  end

  // Set is applied after clear so a new reservation outlives an older commit.
  always_comb begin
    busy_next = busy;
    if (transfer && (sel_addr != '0)) begin
      busy_next[sel_addr] = 1'b0;
    end
    if (RsvValid && (RsvAddr != '0)) begin
      busy_next[RsvAddr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign BusyMask = busy;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed plus randomized bench for reg_wb_arbiter against a transaction-level
// model (rotating priority by modulo arithmetic, scoreboard as a bit array).
module tb_reg_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic              Clk = 1'b0;
  logic              Rst_n;
  logic [NREQ-1:0]   ReqValid;
  logic [NREQ*AW-1:0] ReqAddr;
  logic [NREQ*DW-1:0] ReqData;
  logic [NREQ-1:0]   ReqReady;
  logic              RsvValid;
  logic [AW-1:0]     RsvAddr;
  logic [AW-1:0]     WriteReg;
  logic [DW-1:0]     WriteData;
  logic              RegWriteEn;
  logic [31:0]       BusyMask;

  reg_wb_arbiter #(.NREQ(NREQ), .DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqData(ReqData), .ReqReady(ReqReady),
    .RsvValid(RsvValid), .RsvAddr(RsvAddr),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWriteEn(RegWriteEn),
    .BusyMask(BusyMask)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  int          m_ptr;
  bit [31:0]   m_busy;
  logic [AW-1:0] m_wreg;
  logic [DW-1:0] m_wdata;
  bit          m_we;
  int          last_g;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ReqAddr[i*AW +: AW] = a;
    ReqData[i*DW +: DW] = d;
  endtask

  function automatic int exp_grant();
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (m_ptr + k) % NREQ;
      if (ReqValid[i]) return i;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_busy = '0; m_wreg = '0; m_wdata = '0; m_we = 0; last_g = -1;
  endfunction

  // One clock: check grant, advance model over the edge, check registered outputs.
  task automatic cycle();
    int g;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [NREQ-1:0] exp_rdy;
    bit rv;
    logic [AW-1:0] ra;
    #2;
    g = exp_grant();
    exp_rdy = '0;
    a = '0;
    d = '0;
    if (g >= 0) begin
      exp_rdy[g] = 1'b1;
      a = ReqAddr[g*AW +: AW];
      d = ReqData[g*DW +: DW];
    end
    rv = RsvValid;
    ra = RsvAddr;
    chk("ready", 64'(ReqReady), 64'(exp_rdy));
    @(posedge Clk);
    if (g >= 0) begin
      m_wreg  = a;
      m_wdata = d;
      m_we    = (a != 0);
      m_ptr   = (g + 1) % NREQ;
      if (a != 0) m_busy[a] = 1'b0;
    end else begin
      m_we = 0;
    end
    if (rv && ra != 0) m_busy[ra] = 1'b1;
    last_g = g;
    #1;
    chk("wreg",  64'(WriteReg),   64'(m_wreg));
    chk("wdata", 64'(WriteData),  64'(m_wdata));
    chk("we",    64'(RegWriteEn), 64'(m_we));
    chk("busy",  64'(BusyMask),   64'(m_busy));
    @(negedge Clk);
  endtask

  initial begin
    Rst_n = 1'b0;
    ReqValid = '0; ReqAddr = '0; ReqData = '0;
    RsvValid = 1'b0; RsvAddr = '0;
    model_reset();

    // reset values with all requesters asserting
    ReqValid = 3'b111;
    set_req(0, 5'd1, 32'hA0); set_req(1, 5'd2, 32'hA1); set_req(2, 5'd3, 32'hA2);
    @(posedge Clk); #1;
    chk("rst_ready", 64'(ReqReady), 64'd0);
    chk("rst_we",    64'(RegWriteEn), 64'd0);
    chk("rst_busy",  64'(BusyMask), 64'd0);
    chk("rst_wreg",  64'(WriteReg), 64'd0);
    chk("rst_wdata", 64'(WriteData), 64'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    #1 chk("rr_g0", 64'(ReqReady), 64'b001);
    cycle();
    chk("rr_g1", 64'(ReqReady), 64'b010);
    cycle();
    chk("rr_g2", 64'(ReqReady), 64'b100);
    cycle();
    ReqValid = '0;

    // late requester and wrap
    set_req(1, 5'd8, 32'hDEADBEEF);
    ReqValid = 3'b010;
    cycle();
    chk("late_wreg",  64'(WriteReg), 64'd8);
    chk("late_wdata", 64'(WriteData), 64'hDEADBEEF);
    chk("late_we",    64'(RegWriteEn), 64'd1);
    set_req(0, 5'd7, 32'h11111111);
    set_req(1, 5'd10, 32'h22222222);
    ReqValid = 3'b011;
    #1 chk("wrap_g0", 64'(ReqReady), 64'b001);
    cycle();
    ReqValid = 3'b010;
    cycle();
    ReqValid = '0;

    // register 0 write
    set_req(2, 5'd0, 32'h12345678);
    ReqValid = 3'b100;
    #1 chk("r0_ready", 64'(ReqReady), 64'b100);
    cycle();
    chk("r0_we", 64'(RegWriteEn), 64'd0);
    set_req(1, 5'd4, 32'h44);
    set_req(2, 5'd6, 32'h66);
    ReqValid = 3'b110;
    #1 chk("r0_ptr_adv", 64'(ReqReady), 64'b010);
    cycle();
    ReqValid = 3'b100;
    cycle();
    ReqValid = '0;

    // scoreboard set / clear
    RsvValid = 1'b1; RsvAddr = 5'd5;
    cycle();
    RsvValid = 1'b0;
    chk("sb_set5", 64'(BusyMask[5]), 64'd1);
    set_req(0, 5'd5, 32'h55);
    ReqValid = 3'b001;
    cycle();
    ReqValid = '0;
    chk("sb_clr5",  64'(BusyMask[5]), 64'd0);
    chk("sb_we5",   64'(RegWriteEn), 64'd1);
    chk("sb_wreg5", 64'(WriteReg), 64'd5);

    // simultaneous set and clear
    RsvValid = 1'b1; RsvAddr = 5'd9;
    cycle();
    set_req(0, 5'd9, 32'h99);
    ReqValid = 3'b001;
    cycle();
    RsvValid = 1'b0;
    chk("sim_set_wins", 64'(BusyMask[9]), 64'd1);
    cycle();
    ReqValid = '0;
    chk("sim_later_clr", 64'(BusyMask[9]), 64'd0);

    // async reset mid-stream
    RsvValid = 1'b1; RsvAddr = 5'd5;
    cycle();
    RsvAddr = 5'd9;
    cycle();
    RsvValid = 1'b0;
    set_req(1, 5'd3, 32'h33);
    ReqValid = 3'b010;
    cycle();
    chk("pre_rst_we",   64'(RegWriteEn), 64'd1);
    chk("pre_rst_busy", 64'(BusyMask), 64'h220);
    ReqValid = 3'b111;
    #2 Rst_n = 1'b0;
    #1;
    chk("arst_we",    64'(RegWriteEn), 64'd0);
    chk("arst_wreg",  64'(WriteReg), 64'd0);
    chk("arst_wdata", 64'(WriteData), 64'd0);
    chk("arst_busy",  64'(BusyMask), 64'd0);
    chk("arst_ready", 64'(ReqReady), 64'd0);
    model_reset();
    @(negedge Clk);
    Rst_n = 1'b1;
    set_req(1, 5'd12, 32'hC1);
    set_req(2, 5'd13, 32'hC2);
    ReqValid = 3'b110;
    #1 chk("post_rst_g1", 64'(ReqReady), 64'b010);
    cycle();
    ReqValid[last_g] = 1'b0;

    // randomized traffic obeying the hold-until-granted rule
    for (int n = 0; n < 400; n++) begin
      if (last_g >= 0) ReqValid[last_g] = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (!ReqValid[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, AW'($urandom_range(0, 31)), $urandom);
          ReqValid[i] = 1'b1;
        end
      end
      RsvValid = ($urandom_range(0, 2) == 0);
      RsvAddr  = AW'($urandom_range(0, 31));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
